// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-to-four requester memory arbiter.
// Build option: MEM_ARB_RR_EN selects round-robin arbitration.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } mem_arb_state_t;

    localparam int MEM_ARB_AW       = 4;
    localparam int MEM_ARB_DW       = 8;
    localparam int MEM_ARB_MAX_NREQ = 4;

    // Width of a requester index; never zero so a one-bit field always exists.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Requester and memory-side bundle of the arbiter.
// slave is the arbiter view; master is the requesters plus memory.
interface mem_arb_if #(
    parameter int NREQ = 2,
    parameter int AW   = 4,
    parameter int DW   = 8
);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_wr;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               mem_wr_en;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic [DW-1:0]      mem_rdata;

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata,
        output mem_wr_en, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata,
        input  mem_wr_en, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant picker: one-hot grant plus index.
// MEM_ARB_RR_EN: search from ptr+1; otherwise lowest index wins.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx
);

`ifdef MEM_ARB_RR_EN
    int j;

    // Walk from the farthest slot back; the closest to ptr+1 wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        j       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr) + 1 + k;
            if (j >= NREQ) j = j - NREQ;
            if (j >= NREQ) j = j - NREQ;
            if (req[j]) begin
                gnt     = '0;
                gnt[j]  = 1'b1;
                gnt_idx = IW'(j);
            end
        end
    end
`else
    logic unused_ptr;

    assign unused_ptr = ^ptr;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                gnt     = '0;
                gnt[k]  = 1'b1;
                gnt_idx = IW'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between NREQ requesters, one access per 3 cycles.
// MEM_ARB_RR_EN builds the last-grant pointer for round-robin picking.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = MEM_ARB_AW,
    parameter int DW   = MEM_ARB_DW
) (
    input logic      clk,
    input logic      rst,
    mem_arb_if.slave bus
);

    localparam int IW = idx_w(NREQ);

    mem_arb_state_t  state;
    mem_arb_state_t  state_nx;

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   ptr;
    logic            hs;
    logic [NREQ-1:0] ready;
    logic [NREQ-1:0] rsp;
    logic            wr_en;

    logic [IW-1:0]   g_q;
    logic            wr_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   rdata_q;

    mem_arb_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req     (bus.req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

`ifdef MEM_ARB_RR_EN
    logic [IW-1:0] ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (hs) begin
            ptr_q <= gnt_idx;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // The picker only grants valid requesters, so a grant is a handshake.
    always_comb begin
        state_nx = state;
        ready    = '0;
        rsp      = '0;
        wr_en    = 1'b0;
        hs       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rst && |gnt) begin
                    ready    = gnt;
                    hs       = 1'b1;
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                wr_en    = wr_q;
                state_nx = RESP;
            end
            RESP: begin
                rsp[g_q] = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_q     <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (hs) begin
                g_q     <= gnt_idx;
                wr_q    <= bus.req_wr[gnt_idx];
                addr_q  <= bus.req_addr[gnt_idx*AW +: AW];
                wdata_q <= bus.req_wdata[gnt_idx*DW +: DW];
            end
            if (state == RESP && !wr_q) begin
                rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp;
    assign bus.rsp_rdata = rdata_q;
    assign bus.mem_wr_en = wr_en;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural 16x8 memory.
// Contention expectations follow MEM_ARB_RR_EN.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int NREQ = 2;
    localparam int AW   = 4;
    localparam int DW   = 8;

    typedef struct {
        int       id;
        bit       wr;
        logic [3:0] addr;
        logic [7:0] data;
        int       cyc;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_arb_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [NREQ-1:0] vld = '0;
    logic [NREQ-1:0] wr  = '0;
    logic [AW-1:0]   req_a [NREQ];
    logic [DW-1:0]   req_d [NREQ];

    assign bus.req_valid = vld;
    assign bus.req_wr    = wr;
    assign bus.req_addr  = {req_a[1], req_a[0]};
    assign bus.req_wdata = {req_d[1], req_d[0]};

    logic [7:0] mem    [16] = '{default: 8'h00};
    logic [7:0] shadow [16] = '{default: 8'h00};

    always @(posedge clk) begin
        if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    assign bus.mem_rdata = mem[bus.mem_addr];

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    txn_t sb [$];
    int   glog [$];
    int   clog [$];
    bit   rd_pend  = 0;
    bit   acc_pend = 0;
    logic [7:0] rd_exp;
    txn_t acc;
    txn_t e;
    txn_t h;

    // Monitor: checks the access cycle, response pulse and read data.
    always @(negedge clk) begin
        if (rst) begin
            rd_pend  = 0;
            acc_pend = 0;
        end else begin
            if (rd_pend) begin
                check("rsp_rdata", 32'(bus.rsp_rdata), 32'(rd_exp));
                rd_pend = 0;
            end
            if (acc_pend) begin
                check("mem_addr", 32'(bus.mem_addr), 32'(acc.addr));
                check("mem_wr_en", 32'(bus.mem_wr_en), 32'(acc.wr));
                if (acc.wr) check("mem_wdata", 32'(bus.mem_wdata), 32'(acc.data));
                acc_pend = 0;
            end
            if (bus.rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", 32'(bus.rsp_valid), 32'd1 << e.id);
                    check("rsp_lat", 32'(cyc - e.cyc), 32'd2);
                    if (!e.wr) begin
                        rd_pend = 1;
                        rd_exp  = e.data;
                    end
                end
            end
            if (|bus.req_valid)
                check("ready_1hot", 32'($countones(bus.req_ready) <= 1), 32'd1);
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    h.id   = i;
                    h.wr   = wr[i];
                    h.addr = req_a[i];
                    h.data = wr[i] ? req_d[i] : shadow[req_a[i]];
                    h.cyc  = cyc;
                    if (h.wr) shadow[h.addr] = h.data;
                    sb.push_back(h);
                    glog.push_back(i);
                    clog.push_back(cyc);
                    acc      = h;
                    acc_pend = 1;
                end
            end
        end
    end

    // Returns one time unit after the accepting edge, i.e. in ACCESS.
    task automatic issue(input int r, input bit w, input logic [3:0] ad,
                         input logic [7:0] dt);
        bit done = 0;
        vld[r]   = 1'b1;
        wr[r]    = w;
        req_a[r] = ad;
        req_d[r] = dt;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            if (bus.req_ready[r]) done = 1;
        end
        if (!done) check("hs_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        vld[r] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int exp_order [$];
    int base;
    int n0;
    int n1;
    logic [7:0] old5;

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            req_a[i] = '0;
            req_d[i] = '0;
        end
        idle(2);
        vld[0] = 1'b1;
        #1;
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        vld[0] = 1'b0;
        idle(1);
        rst = 1'b0;
        idle(1);

        // single read and cross-requester coherency, extreme addresses
        issue(0, 1, 4'd3, 8'hA5);
        issue(0, 0, 4'd3, 8'h00);
        issue(1, 1, 4'd15, 8'h3C);
        issue(0, 0, 4'd15, 8'h00);
        issue(0, 1, 4'd0, 8'h11);
        issue(1, 0, 4'd0, 8'h00);
        issue(1, 0, 4'd15, 8'h00);
        idle(4);

        // contention: both requesters hold valid
        base = glog.size();
`ifdef MEM_ARB_RR_EN
        n0 = 3;
        n1 = 3;
        exp_order = '{0, 1, 0, 1, 0, 1};
`else
        n0 = 4;
        n1 = 1;
        exp_order = '{0, 0, 0, 0, 1};
`endif
        fork
            begin
                repeat (n0) issue(0, 0, 4'd3, 8'h00);
            end
            begin
                repeat (n1) issue(1, 0, 4'd15, 8'h00);
            end
        join
        idle(4);
        check("grant_count", 32'(glog.size() - base), 32'(exp_order.size()));
        for (int k = 0; k < exp_order.size() && base + k < glog.size(); k++) begin
            check("grant_order", 32'(glog[base+k]), 32'(exp_order[k]));
            if (k > 0)
                check("hs_gap", 32'(clog[base+k] - clog[base+k-1]), 32'd3);
        end

        // reset during the ACCESS cycle of a write
        old5 = shadow[5];
        issue(0, 1, 4'd5, 8'h77);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_wr_en", 32'(bus.mem_wr_en), 32'd0);
        check("rst_mid_rsp", 32'(bus.rsp_valid), 32'd0);
        sb.delete();
        shadow[5] = old5;
        idle(3);
        check("rst_mid_rdata", 32'(bus.rsp_rdata), 32'd0);
        rst = 1'b0;
        idle(2);
        issue(0, 0, 4'd5, 8'h00);
        idle(4);

        // stall: requester 1 raises valid while the FSM is busy
        issue(0, 0, 4'd3, 8'h00);
        vld[1]   = 1'b1;
        wr[1]    = 1'b1;
        req_a[1] = 4'd9;
        req_d[1] = 8'h5A;
        @(negedge clk);
        check("stall_access", 32'(bus.req_ready[1]), 32'd0);
        @(negedge clk);
        check("stall_resp", 32'(bus.req_ready[1]), 32'd0);
        @(negedge clk);
        check("stall_idle", 32'(bus.req_ready[1]), 32'd1);
        @(posedge clk);
        #1;
        vld[1] = 1'b0;
        issue(0, 0, 4'd9, 8'h00);
        idle(6);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single-port 16x8 `simple_memory` between independent masters, such as CPU data port and DMA engine. Each requester issues reads and writes over a valid/ready handshake and receives a one-cycle response pulse. The arbiter is the only driver of the memory's `wr_en`, `addr` and `data_in`, and is instantiated alongside `simple_memory` in the memory subsystem top.

## Interface
- `NREQ`, default 2: number of requesters; supported range is 2 to 4.
- `AW`, default 4: address width; the memory holds 2^AW words.
- `DW`, default 8: data width.
- `clk`, input, 1: clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `req_valid`, input, NREQ: per-requester request valid.
- `req_ready`, output, NREQ: per-requester accept; at most one bit is high.
- `req_wr`, input, NREQ: 1 = write, 0 = read.
- `req_addr`, input, NREQ*AW: packed addresses; requester i uses `[i*AW +: AW]`.
- `req_wdata`, input, NREQ*DW: packed write data.
- `rsp_valid`, output, NREQ: one-cycle completion pulse per requester.
- `rsp_rdata`, output, DW: read data, shared by all requesters, qualified by `rsp_valid`.
- `mem_wr_en`, output, 1: connects to memory `wr_en`.
- `mem_addr`, output, AW: connects to memory `addr`.
- `mem_wdata`, output, DW: connects to memory `data_in`.
- `mem_rdata`, input, DW: connects from memory `data_out`.

## Operation
- FSM states are IDLE, ACCESS and RESP.
- **IDLE**
  - If any `req_valid` is set, the picker selects a winner g and `req_ready[g]` is driven high combinationally.
  - On the handshake (`req_valid[g] & req_ready[g]`), the FSM latches g, `wr`, `addr` and `wdata` into internal registers and goes to ACCESS.
  - With no requests, the FSM stays in IDLE.
- **ACCESS**
  - `mem_addr` and `mem_wdata` are driven from the latched registers.
  - `mem_wr_en` equals the latched `wr`.
  - Next state is always RESP.
- **RESP**
  - `mem_addr` is held and `mem_wr_en` is 0.
  - `rsp_valid[g]` is 1.
  - For a read, `rsp_rdata` captures `mem_rdata` at the RESP clock edge; the captured value is presented from the following cycle and held until the next read completes.
  - For a write, `rsp_rdata` is unchanged.
  - Next state is IDLE.
- `req_ready` is 0 in ACCESS and RESP. Requesters keep `req_valid` and their payload stable until accepted.
- Responses are never back-pressured.
- There is one outstanding transaction system-wide. No request is reordered or dropped.
- Address arithmetic is none: `req_addr` passes through unmodified. Addresses 0 and 2^AW-1 are ordinary locations with no wrap logic.

## Timing
- Handshake in cycle N puts `mem_wr_en`/`mem_addr` in cycle N+1 and `rsp_valid` in cycle N+2.
- The earliest next handshake is cycle N+3, giving peak throughput of one access per 3 cycles.
- Memory write commits on the clock edge that ends cycle N+1.
- Read data is valid at `mem_rdata` by the end of cycle N+2, which holds for both combinational and registered-read memories.
- **Reset values:**
  - state is IDLE
  - `req_ready` is 0 while `rst` is high
  - `rsp_valid` is 0
  - `rsp_rdata` is 0
  - `mem_wr_en` is 0
  - `mem_addr` is 0
  - `mem_wdata` is 0
  - latched registers are 0
  - round-robin pointer is 0
- **Reset mid-transaction:** `mem_wr_en` drops immediately, because it is asynchronous. The in-flight transaction is abandoned with no `rsp_valid`, and the requester must re-issue it.
- **Simultaneous requests:** exactly one winner per IDLE cycle. Losers see `req_ready` = 0 and remain pending.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - A last-grant pointer updates on every handshake.
  - The search starts at pointer+1 modulo NREQ.
  - No requester waits more than NREQ-1 grants.
- `MEM_ARB_RR_EN` undefined: fixed priority, lowest index wins. The pointer register is not built.

## Structure
- `mem_arb_pkg` contains:
  - the state enum `mem_arb_state_t` (IDLE, ACCESS, RESP)
  - default AW and DW localparams
  - the maximum NREQ constant
- Sub-module `mem_arb_pick`: combinational picker.
  - Inputs are the request vector and the pointer.
  - Output is a one-hot grant plus its index.
  - The `MEM_ARB_RR_EN` branch lives inside this module.

## Test plan
1. **Single read:** preload addr 3 = 0xA5 via requester 0 write, then requester 0 reads addr 3 → `rsp_valid[0]` pulses two cycles after the read handshake, and `rsp_rdata` = 0xA5 from the following cycle.
2. **Cross-requester coherency:** requester 1 writes 0x3C to addr 15, then requester 0 reads addr 15 → 0x3C. Follow with a write of 0x11 to addr 0 and a read-back of 0x11, checking that the two extreme addresses do not alias.
3. **Contention with `MEM_ARB_RR_EN`:** both requesters hold valid for 6 transactions → grant order 0,1,0,1,0,1 with handshakes exactly 3 cycles apart.
4. **Contention without the macro:** both requesters hold valid for 4 transactions → requester 0 is granted all 4 and `req_ready[1]` stays 0 throughout.
5. **Reset in ACCESS of a write** (0x77 to addr 5, location previously 0x00) → `mem_wr_en` is 0 in the same cycle as `rst`, no `rsp_valid`, and after reset a read of addr 5 returns 0x00.
6. **Stall:** requester 1 asserts valid while the FSM is in ACCESS → `req_ready[1]` stays 0 until IDLE, and the payload is latched unchanged on the later handshake.
